// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, branch, memory wait, interrupt entry).
// Optional stall-cycle counter enabled by defining HAZARD_STALL_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] d_src1,
  input  logic              d_src1_vld,
  input  logic [REG_AW-1:0] d_src2,
  input  logic              d_src2_vld,
  input  logic [REG_AW-1:0] e_dst,
  input  logic              e_mem_rd,
  input  logic              e_branch_taken,
  input  logic              m_busy,
  input  logic              irq,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_en,
  output logic              em_en,
  output logic              mw_en,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              mw_flush,
  output logic              irq_ack,
  output logic              mem_err,
  output logic [2:0]        state,
  output logic [15:0]       stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {RUN = 3'd0, MEM_WAIT = 3'd1, IRQ_DRAIN = 3'd2, IRQ_ACK = 3'd3, HALT = 3'd4} state_e;
  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          mem_err_q, mem_err_d;
  logic          lu, br;
  assign lu = e_mem_rd & ((d_src1_vld & (d_src1 == e_dst)) | (d_src2_vld & (d_src2 == e_dst)));
  assign br = e_branch_taken;
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    drain_d   = drain_q;
    mem_err_d = mem_err_q;
    {pc_en, fd_en, de_en, em_en, mw_en} = '1;
    {fd_flush, de_flush, mw_flush, irq_ack} = '0;
    case (state_q)
      HALT: begin
        {pc_en, fd_en, de_en, em_en} = '0;
        mw_flush = 1'b1;
      end
      IRQ_ACK: begin
        irq_ack = 1'b1;
        state_d = RUN;
      end
      default: if (m_busy) begin
        {pc_en, fd_en, de_en, em_en} = '0;
        mw_flush  = 1'b1;
        wait_d    = wait_q + 1'b1;
        mem_err_d = mem_err_q | (wait_d == WW'(MEM_TIMEOUT));
        state_d   = (wait_d == WW'(MEM_TIMEOUT)) ? HALT : (state_q == IRQ_DRAIN) ? IRQ_DRAIN : MEM_WAIT;
      end else begin
        de_flush = br | lu;
        fd_en    = br | ~lu;
        if (state_q == IRQ_DRAIN) begin
          // a taken branch during drain advances the PC so its target becomes the return address
          pc_en    = br;
          fd_flush = br | ~lu;
          drain_d  = drain_q + 1'b1;
          state_d  = (drain_q == DW'(DRAIN_CYCLES - 1)) ? IRQ_ACK : IRQ_DRAIN;
        end else begin
          pc_en    = br | ~lu;
          fd_flush = br;
          drain_d  = '0;
          state_d  = (irq & ~br & ((state_q == MEM_WAIT) | ~lu)) ? IRQ_DRAIN : RUN;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign state   = state_q;
  assign mem_err = mem_err_q;
`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (!pc_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cause-table model of the hazard sequencer.
module tb_pipe_hazard_ctrl;
  localparam int AW = 3, TO = 64, DC = 3;
  localparam logic [8:0] ALL = 9'b11111_000_0, FRZ = 9'b00001_001_0, ACK = 9'b11111_000_1;
  localparam logic [8:0] BRV = 9'b11111_110_0, LUV = 9'b00111_010_0, DRN = 9'b01111_100_0;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] d_src1 = '0, d_src2 = '0, e_dst = 3'd3;
  logic d_src1_vld = 0, d_src2_vld = 0, e_mem_rd = 0, e_branch_taken = 0, m_busy = 0, irq = 0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, irq_ack, mem_err;
  logic [2:0] state;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;
  int md_mode, busy_run, drained, exp_err, exp_stall;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .d_src1(d_src1), .d_src1_vld(d_src1_vld), .d_src2(d_src2),
    .d_src2_vld(d_src2_vld), .e_dst(e_dst), .e_mem_rd(e_mem_rd), .e_branch_taken(e_branch_taken),
    .m_busy(m_busy), .irq(irq), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush), .mw_flush(mw_flush),
    .irq_ack(irq_ack), .mem_err(mem_err), .state(state), .stall_cycles(stall_cycles)
  );
  wire [8:0] dut_vec = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, irq_ack};
  function automatic bit load_use();
    return e_mem_rd && ((d_src1_vld && d_src1 == e_dst) || (d_src2_vld && d_src2 == e_dst));
  endfunction
  function automatic logic [8:0] exp_vec();
    if (md_mode == 4) return FRZ;
    if (md_mode == 3) return ACK;
    if (m_busy) return FRZ;
    if (e_branch_taken) return BRV;
    if (load_use()) return LUV;
    if (md_mode == 2) return DRN;
    return ALL;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [8:0] v;
    v = exp_vec();
    if (rst) begin
      md_mode = 0; busy_run = 0; drained = 0; exp_err = 0; exp_stall = 0;
    end else begin
`ifdef HAZARD_STALL_STATS_EN
      if (!v[8] && exp_stall < 65535) exp_stall++;
`endif
      if (md_mode == 3) begin
        md_mode = 0; busy_run = 0;
      end else if (md_mode != 4) begin
        if (m_busy) begin
          busy_run++;
          if (busy_run == TO) begin md_mode = 4; exp_err = 1; end
          else if (md_mode != 2) md_mode = 1;
        end else begin
          busy_run = 0;
          if (md_mode == 2) begin
            drained++;
            if (drained == DC) md_mode = 3;
          end else begin
            md_mode = (irq && !e_branch_taken && (md_mode == 1 || !load_use())) ? 2 : 0;
            drained = 0;
          end
        end
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    check("outputs", dut_vec, exp_vec());
    check("state", state, md_mode);
    check("mem_err", mem_err, exp_err);
    check("stall_cycles", stall_cycles, exp_stall);
  end
  task automatic cyc(input logic [2:0] s1, input logic v1, input logic [2:0] s2, input logic v2,
                     input logic mr, input logic br, input logic mb, input logic ir);
    @(posedge clk); #1;
    d_src1 = s1; d_src1_vld = v1; d_src2 = s2; d_src2_vld = v2;
    e_mem_rd = mr; e_branch_taken = br; m_busy = mb; irq = ir;
    @(negedge clk);
  endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic busy(); cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic pulse_irq(); cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_outputs", dut_vec, ALL);
    check("reset_mem_err", mem_err, 0);
    cyc(3, 1, 0, 0, 1, 0, 0, 0);
    check("lu_pc_fd_def", {pc_en, fd_en, de_flush}, 3'b001);
    idle();
    check("lu_after", dut_vec, ALL);
    cyc(0, 0, 3, 1, 1, 0, 0, 0);
    check("lu_src2_pc", pc_en, 0);
    cyc(3, 0, 5, 1, 1, 0, 0, 0);
    check("lu_novld_pc", pc_en, 1);
    cyc(3, 1, 0, 0, 1, 1, 0, 0);
    check("lu_br", {pc_en, fd_flush, de_flush}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      busy();
      check("busy_freeze", {pc_en, fd_en, de_en, em_en, mw_en, mw_flush}, 6'b000011);
      if (i > 0) check("busy_state", state, 1);
    end
    idle();
    check("busy_exit", {state, pc_en}, {3'd1, 1'b1});
    idle();
    check("busy_run", state, 0);
    pulse_irq();
    check("irq_pulse", {state, pc_en}, {3'd0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      idle();
      check("drain", {state, pc_en, fd_flush}, {3'd2, 2'b01});
    end
    idle();
    check("ack", {state, irq_ack}, {3'd3, 1'b1});
    idle();
    check("ack_done", {state, irq_ack}, {3'd0, 1'b0});
    pulse_irq();
    idle();
    busy();
    busy();
    check("drain_frozen_state", state, 2);
    idle();
    idle();
    check("ack_delayed_not_yet", irq_ack, 0);
    idle();
    check("ack_delayed", irq_ack, 1);
    pulse_irq();
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check("drain_branch", {pc_en, fd_flush, de_flush}, 3'b111);
    cyc(3, 1, 0, 0, 1, 0, 0, 0);
    check("drain_lu", {pc_en, fd_en, de_flush}, 3'b001);
    idle();
    idle();
    check("ack_third", irq_ack, 1);
    idle();
`ifdef HAZARD_STALL_STATS_EN
    check("stall_total", stall_cycles, 16);
`else
    check("stall_total", stall_cycles, 0);
`endif
    for (int i = 0; i < TO; i++) begin
      busy();
      if (i == TO - 1) check("timeout_edge", state, 1);
    end
    pulse_irq();
    check("halt", {state, mem_err, pc_en, mw_flush}, {3'd4, 3'b101});
    idle();
    check("halt_stays", {state, irq_ack}, {3'd4, 1'b0});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_recover", {state, mem_err, stall_cycles}, 20'd0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
